// File: rtl/cv32e40p_scrub_pkg.sv
// Shared types and constants for the register-file scrubber and its Hamming checker.
// Codeword layout: Hamming position p (1..38) lives at bit p-1; parity sits at powers of two.
package cv32e40p_scrub_pkg;

   localparam int unsigned CW_WIDTH   = 38;
   localparam int unsigned SYN_WIDTH  = 6;
   localparam int unsigned NUM_PARITY = 6;

   // Largest syndrome that names a real bit; anything above is a multi-bit upset.
   localparam logic [SYN_WIDTH-1:0] SYN_MAX = 6'd38;

   localparam int unsigned PARITY_IDX [NUM_PARITY] = '{0, 1, 3, 7, 15, 31};

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCheck,
      StWrite,
      StNext
   } scrub_state_e;

endpackage

// File: rtl/cv32e40p_ham_syndrome.sv
// Combinational Hamming syndrome, classification and single-bit correction
// for one raw 38-bit register-file codeword.
module cv32e40p_ham_syndrome
   import cv32e40p_scrub_pkg::*;
(
   input  logic [CW_WIDTH-1:0]  codeword_i,
   output logic [SYN_WIDTH-1:0] syndrome_o,
   output logic                 correctable_o,
   output logic                 uncorrectable_o,
   output logic [CW_WIDTH-1:0]  corrected_o
);

   // Syndrome bit k: stored parity XOR every data position whose index has bit k set.
   always_comb begin
      syndrome_o = '0;
      for (int unsigned k = 0; k < SYN_WIDTH; k++) begin
         syndrome_o[k] = codeword_i[PARITY_IDX[k]];
         for (int unsigned p = 1; p <= CW_WIDTH; p++) begin
            if ((((p >> k) & 1) == 1) && (p != PARITY_IDX[k] + 1)) begin
               syndrome_o[k] = syndrome_o[k] ^ codeword_i[p-1];
            end
         end
      end
   end

   always_comb begin
      correctable_o   = (syndrome_o != '0) && (syndrome_o <= SYN_MAX);
      uncorrectable_o = (syndrome_o > SYN_MAX);
      corrected_o     = codeword_i;
      if (correctable_o) begin
         corrected_o[syndrome_o - 6'd1] = ~codeword_i[syndrome_o - 6'd1];
      end
   end

endmodule

// File: rtl/cv32e40p_rf_scrubber.sv
// Background scrubber: walks entries 1..NUM_WORDS-1 on idle port C/B slots, rewrites
// single-bit errors and reports uncorrectable words.
module cv32e40p_rf_scrubber
   import cv32e40p_scrub_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned NUM_WORDS  = 64,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scrub_en_i,
   input  logic [15:0]           interval_i,
   input  logic                  rport_free_i,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   input  logic [CW_WIDTH-1:0]   rdata_i,
   input  logic                  ded_i,
   input  logic                  wport_free_i,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [CW_WIDTH-1:0]   wdata_o,
   input  logic                  core_we_a_i,
   input  logic                  core_we_b_i,
   input  logic [ADDR_WIDTH-1:0] core_waddr_a_i,
   input  logic [ADDR_WIDTH-1:0] core_waddr_b_i,
   output logic [CNT_WIDTH-1:0]  corr_cnt_o,
   output logic [CNT_WIDTH-1:0]  ded_cnt_o,
   output logic                  ded_pulse_o,
   output logic [ADDR_WIDTH-1:0] ded_addr_o,
   output logic                  pass_done_o,
   output logic                  busy_o
);

   scrub_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [15:0]           ival_q, ival_d;
   logic                  armed_q, armed_d;
   logic [CW_WIDTH-1:0]   word_q, word_d;
   logic                  ded_in_q, ded_in_d;
   logic                  hazard_q, hazard_d;
   logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_WIDTH-1:0]  ded_cnt_q, ded_cnt_d;
   logic                  ded_pulse_q, ded_pulse_d;
   logic [ADDR_WIDTH-1:0] ded_addr_q, ded_addr_d;
   logic                  pass_done_q, pass_done_d;

   logic [SYN_WIDTH-1:0]  syndrome;
   logic                  syn_corr, syn_uncorr;
   logic [CW_WIDTH-1:0]   corrected;
   logic                  hit, abort, last_word, ded_branch;

   cv32e40p_ham_syndrome u_syndrome (
      .codeword_i      (word_q),
      .syndrome_o      (syndrome),
      .correctable_o   (syn_corr),
      .uncorrectable_o (syn_uncorr),
      .corrected_o     (corrected)
   );

   assign hit = (core_we_a_i && (core_waddr_a_i == ptr_q)) ||
                (core_we_b_i && (core_waddr_b_i == ptr_q));
   // A core write to the target since capture makes our corrected copy stale.
   assign abort      = hazard_q || hit;
   assign last_word  = (ptr_q == ADDR_WIDTH'(NUM_WORDS - 1));
   assign ded_branch = ded_in_q || syn_uncorr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (scrub_en_i && armed_q && (ival_q == '0)) state_d = StRead;
         StRead: begin
            if (!scrub_en_i)       state_d = StIdle;
            else if (rport_free_i) state_d = StCheck;
         end
         StCheck: begin
            if (!scrub_en_i)            state_d = StIdle;
            else if (ded_branch)        state_d = StNext;
            else if (syndrome == '0)    state_d = StNext;
            else if (syn_corr)          state_d = StWrite;
            else                        state_d = StNext;
         end
         StWrite: if (abort || wport_free_i) state_d = StNext;
         StNext:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      raddr_o     = ptr_q;
      waddr_o     = ptr_q;
      wdata_o     = corrected;
      we_o        = (state_q == StWrite) && !abort;
      busy_o      = (state_q != StIdle);
      corr_cnt_o  = corr_cnt_q;
      ded_cnt_o   = ded_cnt_q;
      ded_pulse_o = ded_pulse_q;
      ded_addr_o  = ded_addr_q;
      pass_done_o = pass_done_q;
   end

   always_comb begin
      ptr_d       = ptr_q;
      ival_d      = ival_q;
      armed_d     = armed_q;
      word_d      = word_q;
      ded_in_d    = ded_in_q;
      hazard_d    = hazard_q || hit;
      corr_cnt_d  = corr_cnt_q;
      ded_cnt_d   = ded_cnt_q;
      ded_pulse_d = 1'b0;
      ded_addr_d  = ded_addr_q;
      pass_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!scrub_en_i) begin
               armed_d = 1'b0;
            end else if (!armed_q) begin
               armed_d = 1'b1;
               ival_d  = interval_i;
            end else if (ival_q == '0) begin
               armed_d = 1'b0;
            end else begin
               ival_d = ival_q - 16'd1;
            end
         end
         StRead: begin
            if (scrub_en_i && rport_free_i) begin
               word_d   = rdata_i;
               ded_in_d = ded_i;
               hazard_d = hit;
            end
         end
         StCheck: begin
            if (scrub_en_i) begin
               if (ded_branch) begin
                  if (ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
                  ded_pulse_d = 1'b1;
                  ded_addr_d  = ptr_q;
               end else if (syn_corr) begin
                  if (corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         StNext: begin
            ptr_d       = last_word ? ADDR_WIDTH'(1) : ptr_q + ADDR_WIDTH'(1);
            pass_done_d = last_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= ADDR_WIDTH'(1);
         ival_q      <= '0;
         armed_q     <= 1'b0;
         word_q      <= '0;
         ded_in_q    <= 1'b0;
         hazard_q    <= 1'b0;
         corr_cnt_q  <= '0;
         ded_cnt_q   <= '0;
         ded_pulse_q <= 1'b0;
         ded_addr_q  <= '0;
         pass_done_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         ival_q      <= ival_d;
         armed_q     <= armed_d;
         word_q      <= word_d;
         ded_in_q    <= ded_in_d;
         hazard_q    <= hazard_d;
         corr_cnt_q  <= corr_cnt_d;
         ded_cnt_q   <= ded_cnt_d;
         ded_pulse_q <= ded_pulse_d;
         ded_addr_q  <= ded_addr_d;
         pass_done_q <= pass_done_d;
      end
   end

endmodule
